pc_gen: RTL and testbench
=========================

# pc_gen

Parametrised program-counter generator for the pipelined core's fetch stage. It holds the fetch PC and computes the next PC each cycle from sequential increment, branch/jump redirect, trap vector and a small return-address stack (RAS). A redirect that arrives while fetch is stalled is held in a one-entry pending latch so it is never lost. One cycle of latency from any redirect to `Pc`.

## Interface
- `WIDTH`, 32: PC width in bits.
- `RESET_VEC`, 0: PC value loaded on reset.
- `TRAP_VEC`, 32'h0000_0080: PC loaded on trap.
- `INC`, 4: sequential increment. Must be a power of two ≥1.
- `RAS_DEPTH`, 4: number of return-address stack entries. Must be ≥2.

- `Clk` in 1: clock. All state updates on the posedge.
- `Rst_n` in 1: synchronous, active-low reset.
- `Stall` in 1: 1 = hold PC this cycle.
- `Br_Taken` in 1: branch/jump resolved taken.
- `Br_Target` in WIDTH: redirect target for `Br_Taken`.
- `Call` in 1: the current fetch is a call. Qualified only together with `Br_Taken`.
- `Ret` in 1: the current fetch is a return.
- `Trap` in 1: exception/interrupt redirect.
- `Pc` out WIDTH: current fetch PC, registered.
- `Pc_Valid` out 1: PC is valid for fetch.
- `Misalign` out 1: `Pc` is not a multiple of `INC`. Combinational from `Pc`.
- `Ras_Empty` out 1: RAS holds no entries.
- `Ras_Full` out 1: RAS holds `RAS_DEPTH` entries.
- `Ras_Underflow` out 1: one-cycle pulse on a `Ret` while the RAS is empty.

## Operation
- **Reset** (`Rst_n`=0 at an edge):
  - `Pc`=`RESET_VEC`, `Pc_Valid`=0.
  - Pending latch cleared. RAS count=0, so `Ras_Empty`=1, `Ras_Full`=0.
  - `Ras_Underflow`=0.
  - Reset mid-operation discards all pending and RAS state.
- **Pc_Valid**: goes to 1 at the first edge with `Rst_n`=1. It stays 1 until the next reset.
- **Next-PC priority** (highest first):
  1. `Trap`: next PC = `TRAP_VEC`. Acts even when `Stall`=1. Clears the pending latch and flushes the RAS (count=0).
  2. Stall: when `Stall`=1 and there is no `Trap`, `Pc` holds.
     - If `Br_Taken`, latch `Br_Target` into pending. A later stalled `Br_Taken` overwrites it.
     - `Call`/`Ret` are ignored while stalled.
  3. `Br_Taken` (not stalled): next PC = `Br_Target`.
     - Discards any pending entry.
     - With `Call`: push `Pc`+`INC` onto the RAS.
  4. Pending valid (not stalled): next PC = pending target. Pending is cleared.
  5. `Ret` (not stalled) with RAS non-empty: next PC = RAS top, then pop. With RAS empty: sequential next PC and `Ras_Underflow` pulses.
  6. Otherwise: next PC = `Pc`+`INC`.
- **Arithmetic**: `Pc`+`INC` is modulo 2^WIDTH. Wrap-around from all-ones is silent.
- **RAS**: circular buffer with a top pointer and a count.
  - Push when full overwrites the oldest entry. Count stays at `RAS_DEPTH`, `Ras_Full` stays 1.
  - `Call`+`Ret`+`Br_Taken` in the same unstalled cycle: pop then push, i.e. replace the top. The count is unchanged and next PC = `Br_Target`.
  - `Ret` in the same cycle as a valid pending entry: the pending entry wins and the RAS is untouched.

## Timing
- A redirect (`Trap`, `Br_Taken`, `Ret`) sampled at edge N appears on `Pc` after edge N.
- A stalled redirect appears on `Pc` after the first edge with `Stall`=0.
- Flag timing:
  - `Ras_Empty`/`Ras_Full` are registered and reflect the count after the edge.
  - `Ras_Underflow` is registered and high for exactly one cycle.
  - `Misalign` is combinational from `Pc`: `Pc[log2(INC)-1:0]`≠0, and constant 0 when `INC`=1.
- No combinational path exists from any input to `Pc`, `Pc_Valid` or the RAS flags.

## Structure
- Shared package `pc_pkg` holds:
  - the next-PC select enum: `SEL_SEQ`, `SEL_BR`, `SEL_PEND`, `SEL_RET`, `SEL_TRAP`, `SEL_HOLD`;
  - the default `RESET_VEC`/`TRAP_VEC` constants.
- Sub-module `ras_stack`, parametrised by `WIDTH` and `RAS_DEPTH`:
  - inputs: push, pop, push data;
  - outputs: top, empty, full;
  - plus a flush input.
- `pc_gen` contains:
  - the priority select;
  - the pending latch, one valid bit plus `WIDTH` target bits;
  - the PC register.

## Test plan
- Reset, then release `Rst_n` with default params → `Pc`=0, `Pc_Valid`=1 after the first edge; `Pc` then 4, 8, 12 on successive edges.
- `Stall`=1 for 3 cycles with `Br_Taken` and `Br_Target`=0x200 in the 2nd cycle → `Pc` holds. `Pc`=0x200 after the first unstalled edge, then 0x204.
- Stalled cycle with `Trap`=1 and pending 0x200 → `Pc`=0x80 next edge. Pending is dropped: after un-stalling, `Pc`=0x84.
- At `Pc`=0x10, `Call`+`Br_Taken`(0x400) → `Pc`=0x400. A later `Ret` → `Pc`=0x14 and `Ras_Empty`=1.
- 5 calls from PCs 0x0, 0x100, 0x200, 0x300, 0x400 (RAS_DEPTH=4) → `Ras_Full`=1. Returns yield 0x404, 0x304, 0x204, 0x104. A 5th `Ret` gives sequential next PC and `Ras_Underflow`=1 for one cycle.
- `Pc`=0xFFFF_FFFC, no redirect → `Pc`=0x0. Separately, `Br_Target`=0x102 → `Misalign`=1 while `Pc`=0x102.

Source files
------------

// File: rtl/pc_pkg.sv
// Shared definitions for the fetch PC generator: next-PC select codes and
// default reset/trap vectors.
package pc_pkg;

  typedef enum logic [2:0] {
    SEL_SEQ,
    SEL_BR,
    SEL_PEND,
    SEL_RET,
    SEL_TRAP,
    SEL_HOLD
  } pc_sel_e;

  localparam logic [31:0] DEF_RESET_VEC = 32'h0000_0000;
  localparam logic [31:0] DEF_TRAP_VEC  = 32'h0000_0080;

endpackage

// File: rtl/ras_stack.sv
// Return-address stack: circular buffer with a top pointer and a saturating
// count. A push when full silently overwrites the oldest entry.
module ras_stack #(
  parameter int WIDTH     = 32,
  parameter int RAS_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] push_data,
  output logic [WIDTH-1:0] top,
  output logic             empty,
  output logic             full
);

  localparam int PW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam int CW = $clog2(RAS_DEPTH + 1);
  localparam logic [PW-1:0] LAST = PW'(RAS_DEPTH - 1);
  localparam logic [CW-1:0] MAXC = CW'(RAS_DEPTH);

  logic [RAS_DEPTH-1:0][WIDTH-1:0] mem;
  logic [PW-1:0] tp, tp_inc, tp_dec;
  logic [CW-1:0] cnt;
  logic          do_pop;

  assign tp_inc = (tp == LAST) ? '0 : tp + PW'(1);
  assign tp_dec = (tp == '0) ? LAST : tp - PW'(1);
  assign do_pop = pop && (cnt != '0);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tp  <= '0;
      cnt <= '0;
    end else if (flush) begin
      cnt <= '0;
    end else if (push && !do_pop) begin
      tp <= tp_inc;
      if (cnt != MAXC) cnt <= cnt + CW'(1);
    end else if (do_pop && !push) begin
      tp  <= tp_dec;
      cnt <= cnt - CW'(1);
    end
  end

  // Pop+push on a non-empty stack replaces the top in place.
  always_ff @(posedge clk) begin
    if (rst_n && !flush && push) begin
      if (do_pop) mem[tp]     <= push_data;
      else        mem[tp_inc] <= push_data;
    end
  end

  assign top   = mem[tp];
  assign empty = (cnt == '0);
  assign full  = (cnt == MAXC);

endmodule

// File: rtl/pc_gen.sv
// Fetch-stage program counter: priority next-PC select over trap, stall,
// branch, pending redirect, return and sequential increment.
module pc_gen
  import pc_pkg::*;
#(
  parameter int               WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_VEC = WIDTH'(DEF_RESET_VEC),
  parameter logic [WIDTH-1:0] TRAP_VEC  = WIDTH'(DEF_TRAP_VEC),
  parameter int               INC       = 4,
  parameter int               RAS_DEPTH = 4
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic             Stall,
  input  logic             Br_Taken,
  input  logic [WIDTH-1:0] Br_Target,
  input  logic             Call,
  input  logic             Ret,
  input  logic             Trap,
  output logic [WIDTH-1:0] Pc,
  output logic             Pc_Valid,
  output logic             Misalign,
  output logic             Ras_Empty,
  output logic             Ras_Full,
  output logic             Ras_Underflow
);

  localparam logic [WIDTH-1:0] INC_W = WIDTH'(INC);
  localparam logic [WIDTH-1:0] MASK  = WIDTH'(INC - 1);

  pc_sel_e          sel;
  logic [WIDTH-1:0] next_pc, pc_inc, ras_top;
  logic [WIDTH-1:0] pend_tgt;
  logic             pend_vld;
  logic             ras_push, ras_pop, ras_flush;
  logic             pend_set, pend_clr;

  assign pc_inc = Pc + INC_W;

  // The first edge out of reset only raises Pc_Valid; Pc stays at RESET_VEC.
  always_comb begin
    sel = SEL_SEQ;
    if (!Pc_Valid)                 sel = SEL_HOLD;
    else if (Trap)                 sel = SEL_TRAP;
    else if (Stall)                sel = SEL_HOLD;
    else if (Br_Taken)             sel = SEL_BR;
    else if (pend_vld)             sel = SEL_PEND;
    else if (Ret && !Ras_Empty)    sel = SEL_RET;
  end

  always_comb begin
    next_pc = pc_inc;
    case (sel)
      SEL_TRAP: next_pc = TRAP_VEC;
      SEL_HOLD: next_pc = Pc;
      SEL_BR:   next_pc = Br_Target;
      SEL_PEND: next_pc = pend_tgt;
      SEL_RET:  next_pc = ras_top;
      default:  next_pc = pc_inc;
    endcase
  end

  assign ras_push  = (sel == SEL_BR) && Call;
  assign ras_pop   = (sel == SEL_RET) || (ras_push && Ret);
  assign ras_flush = (sel == SEL_TRAP);
  assign pend_set  = Pc_Valid && !Trap && Stall && Br_Taken;
  assign pend_clr  = (sel == SEL_TRAP) || (sel == SEL_BR) || (sel == SEL_PEND);

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      Pc            <= RESET_VEC;
      Pc_Valid      <= 1'b0;
      pend_vld      <= 1'b0;
      pend_tgt      <= '0;
      Ras_Underflow <= 1'b0;
    end else begin
      Pc            <= next_pc;
      Pc_Valid      <= 1'b1;
      // SEL_SEQ with Ret asserted only happens when the stack is empty.
      Ras_Underflow <= (sel == SEL_SEQ) && Ret;
      if (pend_set) begin
        pend_vld <= 1'b1;
        pend_tgt <= Br_Target;
      end else if (pend_clr) begin
        pend_vld <= 1'b0;
      end
    end
  end

  ras_stack #(
    .WIDTH     (WIDTH),
    .RAS_DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk       (Clk),
    .rst_n     (Rst_n),
    .push      (ras_push),
    .pop       (ras_pop),
    .flush     (ras_flush),
    .push_data (pc_inc),
    .top       (ras_top),
    .empty     (Ras_Empty),
    .full      (Ras_Full)
  );

  assign Misalign = |(Pc & MASK);

endmodule

// File: tb/tb_pc_gen.sv
// Bench for pc_gen: directed plan scenarios plus random traffic, all checked
// against a queue-based reference model of the fetch PC rules.
module tb_pc_gen;

  logic        Clk = 1'b0;
  logic        Rst_n, Stall, Br_Taken, Call, Ret, Trap;
  logic [31:0] Br_Target;
  logic [31:0] Pc;
  logic        Pc_Valid, Misalign, Ras_Empty, Ras_Full, Ras_Underflow;

  int n_chk = 0;
  int n_err = 0;

  // reference model state
  logic [31:0] m_pc;
  bit          m_vld, m_pv, m_uf;
  logic [31:0] m_pt;
  logic [31:0] m_ras[$];

  always #5 Clk = ~Clk;

  pc_gen dut (
    .Clk           (Clk),
    .Rst_n         (Rst_n),
    .Stall         (Stall),
    .Br_Taken      (Br_Taken),
    .Br_Target     (Br_Target),
    .Call          (Call),
    .Ret           (Ret),
    .Trap          (Trap),
    .Pc            (Pc),
    .Pc_Valid      (Pc_Valid),
    .Misalign      (Misalign),
    .Ras_Empty     (Ras_Empty),
    .Ras_Full      (Ras_Full),
    .Ras_Underflow (Ras_Underflow)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic model_step();
    logic [31:0] ret_pc;
    if (!Rst_n) begin
      m_pc = 32'h0; m_vld = 0; m_pv = 0; m_uf = 0;
      m_ras.delete();
      return;
    end
    m_uf = 0;
    if (!m_vld) begin
      m_vld = 1;
      return;
    end
    if (Trap) begin
      m_pc = 32'h80; m_pv = 0;
      m_ras.delete();
    end else if (Stall) begin
      if (Br_Taken) begin m_pv = 1; m_pt = Br_Target; end
    end else if (Br_Taken) begin
      if (Call) begin
        if (Ret && m_ras.size() > 0) ret_pc = m_ras.pop_back();
        m_ras.push_back(m_pc + 32'd4);
        if (m_ras.size() > 4) ret_pc = m_ras.pop_front();
      end
      m_pv = 0;
      m_pc = Br_Target;
    end else if (m_pv) begin
      m_pc = m_pt; m_pv = 0;
    end else if (Ret && m_ras.size() > 0) begin
      m_pc = m_ras.pop_back();
    end else begin
      if (Ret) m_uf = 1;
      m_pc = m_pc + 32'd4;
    end
  endtask

  task automatic compare_all();
    chk("pc",        Pc,                   m_pc);
    chk("pc_valid",  {31'b0, Pc_Valid},    {31'b0, m_vld});
    chk("misalign",  {31'b0, Misalign},    {31'b0, (m_pc % 4) != 0});
    chk("ras_empty", {31'b0, Ras_Empty},   {31'b0, m_ras.size() == 0});
    chk("ras_full",  {31'b0, Ras_Full},    {31'b0, m_ras.size() == 4});
    chk("underflow", {31'b0, Ras_Underflow}, {31'b0, m_uf});
  endtask

  task automatic cyc(input bit rst, input bit st, input bit br, input logic [31:0] tg,
                     input bit ca, input bit re, input bit tr);
    Rst_n = ~rst; Stall = st; Br_Taken = br; Br_Target = tg;
    Call = ca; Ret = re; Trap = tr;
    @(posedge Clk);
    model_step();
    #1;
    compare_all();
  endtask

  task automatic idle();
    cyc(0, 0, 0, 32'h0, 0, 0, 0);
  endtask

  initial begin
    Rst_n = 0; Stall = 0; Br_Taken = 0; Br_Target = 0; Call = 0; Ret = 0; Trap = 0;
    m_pc = 0; m_vld = 0; m_pv = 0; m_uf = 0; m_pt = 0;
    #2;

    // reset and sequential fetch
    cyc(1, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0);
    chk("rst_pc", Pc, 32'h0);
    chk("rst_vld", {31'b0, Pc_Valid}, 32'h0);
    chk("rst_empty", {31'b0, Ras_Empty}, 32'h1);
    idle();
    chk("first_pc", Pc, 32'h0);
    chk("first_vld", {31'b0, Pc_Valid}, 32'h1);
    idle(); chk("seq4", Pc, 32'h4);
    idle(); chk("seq8", Pc, 32'h8);
    idle(); chk("seq12", Pc, 32'hC);

    // stalled branch held in pending
    cyc(0, 1, 0, 0, 0, 0, 0);
    cyc(0, 1, 1, 32'h200, 0, 0, 0);
    cyc(0, 1, 0, 0, 0, 0, 0);
    chk("stall_hold", Pc, 32'hC);
    idle(); chk("pend_tgt", Pc, 32'h200);
    idle(); chk("pend_seq", Pc, 32'h204);

    // trap while stalled drops pending
    cyc(0, 1, 1, 32'h200, 0, 0, 0);
    cyc(0, 1, 0, 0, 0, 0, 1);
    chk("trap_vec", Pc, 32'h80);
    idle(); chk("trap_seq", Pc, 32'h84);

    // call / return
    cyc(0, 0, 1, 32'h10, 0, 0, 0);
    cyc(0, 0, 1, 32'h400, 1, 0, 0);
    chk("call_tgt", Pc, 32'h400);
    cyc(0, 0, 0, 0, 0, 1, 0);
    chk("ret_pc", Pc, 32'h14);
    chk("ret_empty", {31'b0, Ras_Empty}, 32'h1);

    // overflow then underflow
    cyc(0, 0, 1, 32'h0, 0, 0, 0);
    for (int i = 1; i <= 5; i++) cyc(0, 0, 1, 32'h100 * i, 1, 0, 0);
    chk("ras_full", {31'b0, Ras_Full}, 32'h1);
    cyc(0, 0, 0, 0, 0, 1, 0); chk("ret1", Pc, 32'h404);
    cyc(0, 0, 0, 0, 0, 1, 0); chk("ret2", Pc, 32'h304);
    cyc(0, 0, 0, 0, 0, 1, 0); chk("ret3", Pc, 32'h204);
    cyc(0, 0, 0, 0, 0, 1, 0); chk("ret4", Pc, 32'h104);
    cyc(0, 0, 0, 0, 0, 1, 0);
    chk("ret5_seq", Pc, 32'h108);
    chk("uf_pulse", {31'b0, Ras_Underflow}, 32'h1);
    idle(); chk("uf_clear", {31'b0, Ras_Underflow}, 32'h0);

    // call+ret+branch replaces top
    cyc(0, 0, 1, 32'h40, 1, 0, 0);
    cyc(0, 0, 1, 32'h80, 1, 1, 0);
    chk("replace_tgt", Pc, 32'h80);
    cyc(0, 0, 0, 0, 0, 1, 0); chk("replace_ret", Pc, 32'h44);

    // wrap and misalignment
    cyc(0, 0, 1, 32'hFFFF_FFFC, 0, 0, 0);
    idle(); chk("wrap", Pc, 32'h0);
    cyc(0, 0, 1, 32'h102, 0, 0, 0);
    chk("misalign1", {31'b0, Misalign}, 32'h1);
    cyc(0, 0, 1, 32'h100, 0, 0, 0);
    chk("misalign0", {31'b0, Misalign}, 32'h0);

    // random traffic
    for (int n = 0; n < 3000; n++) begin
      bit rs, st, br, ca, re, tr;
      logic [31:0] tg;
      rs = ($urandom_range(0, 99) == 0);
      st = ($urandom_range(0, 9) < 3);
      br = ($urandom_range(0, 3) == 0);
      ca = br && ($urandom_range(0, 1) == 1);
      re = ($urandom_range(0, 4) == 0);
      tr = ($urandom_range(0, 32) == 0);
      tg = {20'h0, 10'($urandom_range(0, 1023)), 2'b00};
      if ($urandom_range(0, 15) == 0) tg = tg + 32'd2;
      if (br && re) ca = 1;
      if (br && re && m_ras.size() == 0) re = 0;
      cyc(rs, st, br, tg, ca, re, tr);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
